// File: rtl/multicycle_main_controller.sv
`default_nettype none
// multicycle_main_controller: multi-cycle RV32I control FSM sharing one memory port,
// with a ready/timeout memory handshake, illegal/bus-error traps and a retire pulse.
module multicycle_main_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit EXT_J       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       regwrite,
  output logic       branch,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
    MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECR  = 4'd6,  EXECI   = 4'd7,
    ALUWB    = 4'd8,  BRANCH  = 4'd9,  JAL    = 4'd10, JALR    = 4'd11,
    JALR_PC  = 4'd12, LUI     = 4'd13, AUIPC  = 4'd14, TRAP    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int        CW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(MEM_TIMEOUT);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [CW:0]   cnt_inc;
  logic          in_wait, timeout_hit;
  logic          illegal_q, bus_err_q, set_ill, set_be;
  logic          req_c, we_c, adr_c, irw_c, pcw_c, rw_c, br_c, ret_c;
  logic [1:0]    a_c, b_c, aluop_c, rs_c;
  logic [2:0]    imm_c;

  assign cnt_inc     = {1'b0, wait_cnt} + 1'b1;
  assign in_wait     = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  // The limit is hit on the MEM_TIMEOUT-th consecutive low cycle; a ready in that cycle still wins.
  assign timeout_hit = (MEM_TIMEOUT != 0) && in_wait && !mem_ready && (cnt_inc == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= illegal_q | set_ill;
      bus_err_q <= bus_err_q | set_be;
      if ((MEM_TIMEOUT == 0) || mem_ready || !in_wait || (state_nxt != state))
        wait_cnt <= '0;
      else if (cnt_inc <= LIMIT)
        wait_cnt <= cnt_inc[CW-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    req_c = 1'b0; we_c = 1'b0; adr_c = 1'b0; irw_c = 1'b0;
    pcw_c = 1'b0; rw_c = 1'b0; br_c = 1'b0; ret_c = 1'b0;
    a_c = 2'b00; b_c = 2'b00; aluop_c = 2'b00; rs_c = 2'b00;
    set_ill = 1'b0; set_be = 1'b0;
    case (state)
      FETCH: begin
        req_c = 1'b1; b_c = 2'b10; rs_c = 2'b10;
        irw_c = mem_ready; pcw_c = mem_ready;
        if (mem_ready) state_nxt = DECODE;
        else if (timeout_hit) begin state_nxt = TRAP; set_be = 1'b1; end
      end
      DECODE: begin
        a_c = 2'b01; b_c = 2'b01;
        if (op == OP_LOAD || op == OP_STORE)  state_nxt = MEMADR;
        else if (op == OP_RTYPE)              state_nxt = EXECR;
        else if (op == OP_ITYPE)              state_nxt = EXECI;
        else if (op == OP_BRANCH)             state_nxt = BRANCH;
        else if (EXT_J && op == OP_JAL)       state_nxt = JAL;
        else if (EXT_J && op == OP_JALR)      state_nxt = JALR;
        else if (EXT_J && op == OP_LUI)       state_nxt = LUI;
        else if (EXT_J && op == OP_AUIPC)     state_nxt = AUIPC;
        else begin state_nxt = TRAP; set_ill = 1'b1; end
      end
      MEMADR: begin
        a_c = 2'b10; b_c = 2'b01;
        state_nxt = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        req_c = 1'b1; adr_c = 1'b1;
        if (mem_ready) state_nxt = MEMWB;
        else if (timeout_hit) begin state_nxt = TRAP; set_be = 1'b1; end
      end
      MEMWB: begin
        rs_c = 2'b01; rw_c = 1'b1; ret_c = 1'b1; state_nxt = FETCH;
      end
      MEMWRITE: begin
        req_c = 1'b1; we_c = 1'b1; adr_c = 1'b1; ret_c = mem_ready;
        if (mem_ready) state_nxt = FETCH;
        else if (timeout_hit) begin state_nxt = TRAP; set_be = 1'b1; end
      end
      EXECR:   begin a_c = 2'b10; b_c = 2'b00; aluop_c = 2'b10; state_nxt = ALUWB; end
      EXECI:   begin a_c = 2'b10; b_c = 2'b01; aluop_c = 2'b11; state_nxt = ALUWB; end
      ALUWB:   begin rw_c = 1'b1; ret_c = 1'b1; state_nxt = FETCH; end
      BRANCH: begin
        a_c = 2'b10; aluop_c = 2'b01; br_c = 1'b1; pcw_c = zero; ret_c = 1'b1;
        state_nxt = FETCH;
      end
      JAL:     begin a_c = 2'b01; b_c = 2'b10; pcw_c = 1'b1; state_nxt = ALUWB; end
      JALR:    begin a_c = 2'b10; b_c = 2'b01; state_nxt = JALR_PC; end
      JALR_PC: begin a_c = 2'b01; b_c = 2'b10; pcw_c = 1'b1; state_nxt = ALUWB; end
      LUI:     begin a_c = 2'b11; b_c = 2'b01; state_nxt = ALUWB; end
      AUIPC:   begin a_c = 2'b01; b_c = 2'b01; state_nxt = ALUWB; end
      default: ;
    endcase
  end

  always_comb begin
    imm_c = 3'b000;
    case (op)
      OP_STORE:        imm_c = 3'b001;
      OP_BRANCH:       imm_c = 3'b010;
      OP_JAL:          imm_c = 3'b011;
      OP_LUI, OP_AUIPC: imm_c = 3'b100;
      default:         imm_c = 3'b000;
    endcase
  end

  // Reset masks the decoded controls combinationally so the datapath idles while rst_n is low.
  assign mem_req    = rst_n & req_c;
  assign mem_we     = rst_n & we_c;
  assign adr_src    = rst_n & adr_c;
  assign ir_write   = rst_n & irw_c;
  assign pc_write   = rst_n & pcw_c;
  assign regwrite   = rst_n & rw_c;
  assign branch     = rst_n & br_c;
  assign retire     = rst_n & ret_c;
  assign alu_src_a  = rst_n ? a_c     : 2'b00;
  assign alu_src_b  = rst_n ? b_c     : 2'b00;
  assign aluop      = rst_n ? aluop_c : 2'b00;
  assign result_src = rst_n ? rs_c    : 2'b00;
  assign imm_src    = rst_n ? imm_c   : 3'b000;
  assign illegal    = illegal_q;
  assign bus_err    = bus_err_q;
  assign state_o    = state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_controller.sv
`default_nettype none
// tb_multicycle_main_controller: random instruction stream against an instruction-level model,
// checked per cycle through a scoreboard queue; plus directed reset/timeout/EXT_J=0 cases.
module tb_multicycle_main_controller;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_JAL = 10, S_JALR = 11, S_JALR_PC = 12, S_LUI = 13, S_AUIPC = 14, S_TRAP = 15;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, adr_src, ir_write, pc_write, regwrite, branch, retire, illegal, bus_err;
  logic [1:0] alu_src_a, alu_src_b, aluop, result_src;
  logic [2:0] imm_src;
  logic [3:0] state_o;

  logic rst_b = 1'b0;
  logic [6:0] op_b = 7'd0;
  logic rdy_b = 1'b0;
  logic req_b, we_b, adr_b, irw_b, pcw_b, rw_b, br_b, ret_b, ill_b, be_b;
  logic [1:0] a_b, bsel_b, aluop_b, rs_b;
  logic [2:0] imm_b;
  logic [3:0] st_b;

  int n_tests = 0, n_fail = 0;
  logic [24:0] sb[$];
  logic [6:0] cur_op = 7'd0;
  logic m_ill = 1'b0, m_be = 1'b0;
  logic [24:0] dut_vec;

  always #5 clk = ~clk;

  multicycle_main_controller #(.MEM_TIMEOUT(TMO), .EXT_J(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .regwrite(regwrite), .branch(branch), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .result_src(result_src), .imm_src(imm_src),
    .retire(retire), .illegal(illegal), .bus_err(bus_err), .state_o(state_o));

  multicycle_main_controller #(.MEM_TIMEOUT(0), .EXT_J(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b), .op(op_b), .zero(1'b0), .mem_ready(rdy_b),
    .mem_req(req_b), .mem_we(we_b), .adr_src(adr_b), .ir_write(irw_b),
    .pc_write(pcw_b), .regwrite(rw_b), .branch(br_b), .alu_src_a(a_b),
    .alu_src_b(bsel_b), .aluop(aluop_b), .result_src(rs_b), .imm_src(imm_b),
    .retire(ret_b), .illegal(ill_b), .bus_err(be_b), .state_o(st_b));

  assign dut_vec = {mem_req, mem_we, adr_src, ir_write, pc_write, regwrite, branch,
                    alu_src_a, alu_src_b, aluop, result_src, imm_src, retire, illegal, bus_err, state_o};

  // Expected control word for one cycle spent in state st, written as a per-state table.
  function automatic logic [24:0] exp_vec(input int st, input logic [6:0] o, input logic rdy,
                                          input logic z, input logic ill, input logic be);
    logic req, we, adr, irw, pcw, rw, br, ret;
    logic [1:0] a, b, al, rs;
    logic [2:0] imm;
    {req, we, adr, irw, pcw, rw, br, ret} = '0;
    {a, b, al, rs} = '0;
    case (st)
      S_FETCH:    begin req = 1; b = 2; rs = 2; irw = rdy; pcw = rdy; end
      S_DECODE:   begin a = 1; b = 1; end
      S_MEMADR:   begin a = 2; b = 1; end
      S_MEMREAD:  begin req = 1; adr = 1; end
      S_MEMWB:    begin rs = 1; rw = 1; ret = 1; end
      S_MEMWRITE: begin req = 1; we = 1; adr = 1; ret = rdy; end
      S_EXECR:    begin a = 2; b = 0; al = 2; end
      S_EXECI:    begin a = 2; b = 1; al = 3; end
      S_ALUWB:    begin rw = 1; ret = 1; end
      S_BRANCH:   begin a = 2; al = 1; br = 1; pcw = z; ret = 1; end
      S_JAL:      begin a = 1; b = 2; pcw = 1; end
      S_JALR:     begin a = 2; b = 1; end
      S_JALR_PC:  begin a = 1; b = 2; pcw = 1; end
      S_LUI:      begin a = 3; b = 1; end
      S_AUIPC:    begin a = 1; b = 1; end
      default:    ;
    endcase
    case (o)
      7'b0100011: imm = 3'b001;
      7'b1100011: imm = 3'b010;
      7'b1101111: imm = 3'b011;
      7'b0110111, 7'b0010111: imm = 3'b100;
      default: imm = 3'b000;
    endcase
    return {req, we, adr, irw, pcw, rw, br, a, b, al, rs, imm, ret, ill, be, 4'(st)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      logic [24:0] e;
      e = sb.pop_front();
      check($sformatf("ctrl st=%0d", e[3:0]), {7'd0, dut_vec}, {7'd0, e});
    end
  end

  // One cycle in state st: drive inputs, queue the expected word, advance to posedge+1.
  task automatic cycle(input int st, input logic rdy);
    logic z;
    z = 1'($urandom_range(0, 1));
    op = cur_op; mem_ready = rdy; zero = z;
    sb.push_back(exp_vec(st, cur_op, rdy, z, m_ill, m_be));
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input int st, input int nw, output bit trapped);
    trapped = 0;
    for (int k = 0; k < nw; k++) begin
      cycle(st, 1'b0);
      if (k + 1 == TMO) begin trapped = 1; m_be = 1'b1; return; end
    end
    cycle(st, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m_ill = 1'b0; m_be = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic trap_tail();
    repeat (3) cycle(S_TRAP, 1'($urandom_range(0, 1)));
    do_reset();
  endtask

  task automatic run_instr(input logic [6:0] o, input int fw, input int mw);
    bit t;
    cur_op = o;
    wait_state(S_FETCH, fw, t);
    if (t) begin trap_tail(); return; end
    cycle(S_DECODE, 1'($urandom_range(0, 1)));
    case (o)
      7'b0000011: begin
        cycle(S_MEMADR, 1'($urandom_range(0, 1)));
        wait_state(S_MEMREAD, mw, t);
        if (t) begin trap_tail(); return; end
        cycle(S_MEMWB, 1'($urandom_range(0, 1)));
      end
      7'b0100011: begin
        cycle(S_MEMADR, 1'($urandom_range(0, 1)));
        wait_state(S_MEMWRITE, mw, t);
        if (t) begin trap_tail(); return; end
      end
      7'b0110011: begin cycle(S_EXECR, 1'b1); cycle(S_ALUWB, 1'b0); end
      7'b0010011: begin cycle(S_EXECI, 1'b0); cycle(S_ALUWB, 1'b1); end
      7'b1100011: cycle(S_BRANCH, 1'($urandom_range(0, 1)));
      7'b1101111: begin cycle(S_JAL, 1'b0); cycle(S_ALUWB, 1'b0); end
      7'b1100111: begin cycle(S_JALR, 1'b1); cycle(S_JALR_PC, 1'b0); cycle(S_ALUWB, 1'b1); end
      7'b0110111: begin cycle(S_LUI, 1'b0); cycle(S_ALUWB, 1'b0); end
      7'b0010111: begin cycle(S_AUIPC, 1'b1); cycle(S_ALUWB, 1'b0); end
      default: begin m_ill = 1'b1; trap_tail(); end
    endcase
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 20;
    if (r == 1) return TMO - 1;
    return r % 4;
  endfunction

  logic [6:0] ops [12] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111,
                           7'b0000000, 7'b1111111, 7'b0001111};

  initial begin
    #1;
    check("reset_vec", {7'd0, dut_vec}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0000011, 0, 3);
    run_instr(7'b1100011, 1, 0);
    run_instr(7'b1100111, 0, 0);
    run_instr(7'b0110011, TMO - 1, 0);
    run_instr(7'b0010011, 20, 0);
    run_instr(7'b0001111, 0, 0);

    // Reset asserted while a store waits on memory.
    cur_op = 7'b0100011;
    cycle(S_FETCH, 1'b1); cycle(S_DECODE, 1'b0); cycle(S_MEMADR, 1'b0);
    cycle(S_MEMWRITE, 1'b0); cycle(S_MEMWRITE, 1'b0);
    rst_n = 1'b0; mem_ready = 1'b0; m_ill = 1'b0; m_be = 1'b0;
    #1;
    check("rst_midwait", {7'd0, dut_vec}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_release", {7'd0, dut_vec}, {7'd0, exp_vec(S_FETCH, cur_op, 1'b0, zero, 1'b0, 1'b0)});

    for (int i = 0; i < 300; i++)
      run_instr(ops[$urandom_range(0, 11)], rand_wait(), rand_wait());

    // EXT_J=0, MEM_TIMEOUT=0 instance.
    @(posedge clk); #1;
    rst_b = 1'b1; op_b = 7'b1100111; rdy_b = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("b_no_timeout_state", {28'd0, st_b}, 32'd0);
    check("b_no_bus_err", {31'd0, be_b}, 32'd0);
    rdy_b = 1'b1;
    @(posedge clk); #1;
    check("b_decode", {28'd0, st_b}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("b_trap_state", {28'd0, st_b}, 32'd15);
    check("b_illegal", {31'd0, ill_b}, 32'd1);
    check("b_trap_quiet", {30'd0, req_b, pcw_b}, 32'd0);

    @(posedge clk); #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_main_controller.md
Name: multicycle_main_controller

Overview:
- Parametrised successor to the single-cycle main decoder: a Moore FSM that sequences the RV32I subset over multiple cycles with one shared memory port.
- Adds a variable-latency memory handshake (mem_req/mem_ready) with a timeout, optional jump/upper-immediate support, illegal-opcode and bus-error traps, and a retire pulse.
- Sits between the instruction register and the datapath muxes, PC, register file and memory interface.

Parameters:
- MEM_TIMEOUT, 15: maximum number of consecutive mem_ready-low cycles in a memory state before a bus-error trap; 0 disables the timeout.
- EXT_J, 1: 1 decodes jal(1101111), jalr(1100111), lui(0110111) and auipc(0010111); 0 treats those opcodes as illegal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode field of the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write request; valid only while mem_req=1.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the IR and oldPC.
- pc_write  out  1  load the PC from the result bus.
- regwrite  out  1  register-file write.
- branch  out  1  high in BRANCH state.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- aluop  out  2  00 = add, 01 = branch compare (sub), 10 = R-type funct, 11 = I-type funct.
- result_src  out  2  result bus select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- imm_src  out  3  immediate format: I = 000, S = 001, B = 010, J = 011, U = 100.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  sticky: illegal opcode trap taken.
- bus_err  out  1  sticky: memory timeout trap taken.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset:
  - state = FETCH, wait counter = 0, illegal = bus_err = 0.
  - All control outputs are forced to 0 while rst_n = 0.
  - Asserting rst_n low mid-instruction or mid-wait abandons the operation immediately.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALR_PC 12, LUI 13, AUIPC 14, TRAP 15.
- Default value of every unlisted control output in any state is 0.
- imm_src is decoded combinationally from op in every state:
  - 0100011 → S; 1100011 → B; 1101111 → J; 0110111 and 0010111 → U; all others → I.
- Per-state controls and transitions:
  - FETCH: mem_req=1, adr_src=0, a=00, b=10, aluop=00, result_src=10. ir_write = pc_write = mem_ready. Move to DECODE on mem_ready, otherwise hold.
  - DECODE: a=01, b=01, aluop=00 (branch/jal target into ALUOut). Dispatch on op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - with EXT_J=1: 1101111 → JAL, 1100111 → JALR, 0110111 → LUI, 0010111 → AUIPC
    - anything else → TRAP with illegal=1.
  - MEMADR: a=10, b=01, aluop=00. op=0000011 → MEMREAD, else → MEMWRITE.
  - MEMREAD: mem_req=1, adr_src=1. Move to MEMWB on mem_ready.
  - MEMWB: result_src=01, regwrite=1, retire=1 → FETCH.
  - MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready: retire=1 → FETCH.
  - EXECR: a=10, b=00, aluop=10 → ALUWB.
  - EXECI: a=10, b=01, aluop=11 → ALUWB.
  - ALUWB: result_src=00, regwrite=1, retire=1 → FETCH.
  - BRANCH: a=10, b=00, aluop=01, result_src=00, branch=1, pc_write=zero, retire=1 → FETCH.
  - JAL: a=01, b=10, result_src=00, pc_write=1 → ALUWB (rd = oldPC+4).
  - JALR: a=10, b=01 → JALR_PC.
  - JALR_PC: result_src=00, pc_write=1, a=01, b=10 → ALUWB.
  - LUI: a=11, b=01 → ALUWB.
  - AUIPC: a=01, b=01 → ALUWB.
  - TRAP: all controls 0, no retire. Absorbing; exits only through reset.
- Timeout:
  - The wait counter increments in FETCH, MEMREAD or MEMWRITE on each cycle with mem_ready=0, and clears on mem_ready or on leaving the state.
  - With MEM_TIMEOUT>0, the counter reaching MEM_TIMEOUT moves the FSM to TRAP with bus_err=1, and mem_req drops next cycle.
  - A mem_ready arriving in the same cycle as the limit is reached completes the access normally; no trap.
  - Counter width is clog2(MEM_TIMEOUT+1) and the counter saturates; with MEM_TIMEOUT=0 the counter is held at 0.

Test Plan:
- R-type add, op=0110011, mem_ready tied 1 → FETCH, DECODE, EXECR, ALUWB. regwrite only in cycle 4; retire at cycle 4; aluop=10 in EXECR.
- Load, op=0000011, mem_ready low 3 cycles in MEMREAD → state sequence 0, 1, 2, 3, 3, 3, 3, 4. result_src=01 and regwrite=1 in MEMWB; exactly 1 retire.
- beq, op=1100011: with zero=1 → pc_write=1 in BRANCH; with zero=0 → pc_write=0. Both cases: imm_src=010, back to FETCH after 3 cycles.
- jalr with EXT_J=1 → states 0, 1, 11, 12, 8. pc_write high in FETCH and JALR_PC only. Same opcode with EXT_J=0 → TRAP, illegal=1, state_o=15 held.
- MEM_TIMEOUT=15, mem_ready=0 in FETCH → TRAP after 15 wait cycles, bus_err=1. Same setup with mem_ready=1 on the 15th cycle → DECODE, no trap.
- rst_n asserted low during MEMWRITE wait → all outputs 0 in the same cycle. On release: state 0, mem_req=1, adr_src=0, flags cleared.
